// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU control codes and datapath mux selects.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StHalt     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, selects and enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           imm_src, reg_write, alu_control, instr_done, illegal_op
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           imm_src, reg_write, alu_control, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller_alu_ctrl_decode.sv
// Maps the FSM's alu_op plus funct3/funct7 to the 3-bit ALU control code.
module alu_ctrl_decode
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7_i is already qualified by op[5], so addi cannot subtract
          3'b000:  alu_control_o = funct7_i ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I subset core; sequences one instruction at a
// time over the shared memory port, ALU, PC, IR and register file.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter logic [3:0]  RESET_STATE  = 4'd0,
  parameter int unsigned ILLEGAL_TRAP = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic       instr_done_raw, illegal_op_raw;
  logic       adr_src, result_src_unused;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  assign result_src_unused = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    alu_op         = ALUOP_ADD;
    pc_update      = 1'b0;
    branch         = 1'b0;
    adr_src        = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    illegal_op_raw = 1'b0;
    result_src     = RES_ALUOUT;
    alu_src_a      = SRCA_PC;
    alu_src_b      = SRCB_RD2;

    case (state_q)
      StFetch: begin
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        ir_write_raw = bus.mem_ready;
        pc_update    = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch/jump target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecR;
          OP_I:         state_d = StExecI;
          OP_BEQ:       state_d = StBeq;
          OP_JAL:       state_d = StJal;
          default: begin
            illegal_op_raw = 1'b1;
            state_d        = (ILLEGAL_TRAP != 0) ? StHalt : StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        if (bus.op == OP_LW)      state_d = StMemRead;
        else if (bus.op == OP_SW) state_d = StMemWrite;
        else                      state_d = StFetch;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src     = RES_DATA;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = StFetch;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (bus.mem_ready) begin
          instr_done_raw = 1'b1;
          state_d        = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = StFetch;
      end
      StBeq: begin
        alu_src_a      = SRCA_RD1;
        alu_op         = ALUOP_SUB;
        branch         = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = StFetch;
      end
      StJal: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  assign pc_write_raw = pc_update | (branch & bus.zero);

  always_comb begin
    case (bus.op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_ctrl_decode u_alu_ctrl_decode (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .funct7_i      (bus.op[5] & bus.funct7b5),
    .alu_control_o (alu_control)
  );

  // Reset masks every side-effecting strobe so an abandoned instruction never commits
  assign bus.pc_write    = pc_write_raw   & ~reset;
  assign bus.ir_write    = ir_write_raw   & ~reset;
  assign bus.mem_write   = mem_write_raw  & ~reset;
  assign bus.reg_write   = reg_write_raw  & ~reset;
  assign bus.instr_done  = instr_done_raw & ~reset;
  assign bus.illegal_op  = illegal_op_raw & ~reset & ~result_src_unused;
  assign bus.adr_src     = adr_src;
  assign bus.result_src  = result_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.imm_src     = imm_src;
  assign bus.alu_control = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one DUT with the default illegal handling,
// one with ILLEGAL_TRAP = 1 fed the same inputs.
module tb_multicycle_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_controller_if bus ();
  multicycle_controller_if bus_t ();

  multicycle_controller #(
    .RESET_STATE  (4'd0),
    .ILLEGAL_TRAP (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  multicycle_controller #(
    .RESET_STATE  (4'd0),
    .ILLEGAL_TRAP (1)
  ) dut_trap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_t)
  );

  assign bus_t.op        = bus.op;
  assign bus_t.funct3    = bus.funct3;
  assign bus_t.funct7b5  = bus.funct7b5;
  assign bus_t.zero      = bus.zero;
  assign bus_t.mem_ready = bus.mem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.op         = 7'b0000000;
    bus.funct3     = 3'b000;
    bus.funct7b5   = 1'b0;
    bus.zero       = 1'b0;
    bus.mem_ready  = 1'b1;

    // Reset for two cycles; strobes masked while reset is high
    cyc();
    cyc();
    check("rst_ir_write", {7'd0, bus.ir_write}, 8'd0);
    check("rst_pc_write", {7'd0, bus.pc_write}, 8'd0);
    reset = 1'b0;

    // R-type sub, cycle 1 = FETCH
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    #1;
    check("fetch_ir_write", {7'd0, bus.ir_write}, 8'd1);
    check("fetch_pc_write", {7'd0, bus.pc_write}, 8'd1);
    check("fetch_src_b", {6'd0, bus.alu_src_b}, 8'd2);
    check("fetch_alu_ctl", {5'd0, bus.alu_control}, 8'd0);
    check("fetch_res_src", {6'd0, bus.result_src}, 8'd2);
    cyc();
    check("dec_src_a", {6'd0, bus.alu_src_a}, 8'd1);
    check("dec_src_b", {6'd0, bus.alu_src_b}, 8'd1);
    check("dec_ir_write", {7'd0, bus.ir_write}, 8'd0);
    cyc();
    check("execr_sub", {5'd0, bus.alu_control}, 8'd1);
    check("execr_src_a", {6'd0, bus.alu_src_a}, 8'd2);
    check("execr_done", {7'd0, bus.instr_done}, 8'd0);
    cyc();
    check("aluwb_reg_write", {7'd0, bus.reg_write}, 8'd1);
    check("aluwb_done", {7'd0, bus.instr_done}, 8'd1);
    cyc();
    check("r_back_fetch", {7'd0, bus.ir_write}, 8'd1);

    // addi with bit30 set must still add
    bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    cyc();
    cyc();
    check("execi_addi", {5'd0, bus.alu_control}, 8'd0);
    check("execi_imm_src", {6'd0, bus.imm_src}, 8'd0);
    check("execi_src_b", {6'd0, bus.alu_src_b}, 8'd1);
    bus.funct3 = 3'b110;
    #1;
    check("execi_ori", {5'd0, bus.alu_control}, 8'd3);
    bus.funct3 = 3'b010;
    #1;
    check("execi_slti", {5'd0, bus.alu_control}, 8'd5);
    cyc();
    check("execi_wb_done", {7'd0, bus.instr_done}, 8'd1);
    cyc();

    // lw with three wait cycles in MEMREAD: 8 cycles total
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
    #1;
    check("lw_fetch", {7'd0, bus.ir_write}, 8'd1);
    cyc();
    cyc();
    check("lw_memadr_src_a", {6'd0, bus.alu_src_a}, 8'd2);
    check("lw_memadr_ctl", {5'd0, bus.alu_control}, 8'd0);
    cyc();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_wait_adr_src", {7'd0, bus.adr_src}, 8'd1);
      check("lw_wait_reg_write", {7'd0, bus.reg_write}, 8'd0);
      if (i < 2) cyc();
    end
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("lw_ready_adr_src", {7'd0, bus.adr_src}, 8'd1);
    check("lw_ready_res_src", {6'd0, bus.result_src}, 8'd0);
    cyc();
    check("memwb_res_src", {6'd0, bus.result_src}, 8'd1);
    check("memwb_reg_write", {7'd0, bus.reg_write}, 8'd1);
    check("memwb_done", {7'd0, bus.instr_done}, 8'd1);
    cyc();

    // beq taken
    bus.op = 7'b1100011; bus.funct3 = 3'b000; bus.zero = 1'b1;
    #1;
    check("beq_imm_src", {6'd0, bus.imm_src}, 8'd2);
    cyc();
    cyc();
    check("beq_t_pc_write", {7'd0, bus.pc_write}, 8'd1);
    check("beq_t_alu_ctl", {5'd0, bus.alu_control}, 8'd1);
    check("beq_t_done", {7'd0, bus.instr_done}, 8'd1);
    cyc();
    check("beq_t_fetch", {7'd0, bus.ir_write}, 8'd1);

    // beq not taken
    bus.zero = 1'b0;
    cyc();
    cyc();
    check("beq_nt_pc_write", {7'd0, bus.pc_write}, 8'd0);
    check("beq_nt_done", {7'd0, bus.instr_done}, 8'd1);
    cyc();
    check("beq_nt_fetch", {7'd0, bus.ir_write}, 8'd1);

    // jal
    bus.op = 7'b1101111;
    #1;
    check("jal_imm_src", {6'd0, bus.imm_src}, 8'd3);
    cyc();
    cyc();
    check("jal_pc_write", {7'd0, bus.pc_write}, 8'd1);
    check("jal_src_a", {6'd0, bus.alu_src_a}, 8'd1);
    check("jal_src_b", {6'd0, bus.alu_src_b}, 8'd2);
    cyc();
    check("jal_wb_reg_write", {7'd0, bus.reg_write}, 8'd1);
    check("jal_wb_res_src", {6'd0, bus.result_src}, 8'd0);
    check("jal_wb_done", {7'd0, bus.instr_done}, 8'd1);
    cyc();

    // Illegal opcode: both DUTs pulse, only dut_trap halts
    bus.op = 7'b1111111;
    cyc();
    check("ill_pulse", {7'd0, bus.illegal_op}, 8'd1);
    check("ill_pulse_trap", {7'd0, bus_t.illegal_op}, 8'd1);
    cyc();
    check("ill_back_fetch", {7'd0, bus.ir_write}, 8'd1);
    check("ill_pulse_gone", {7'd0, bus.illegal_op}, 8'd0);
    bus.op = 7'b0100011;
    #1;
    check("halt_enables", {4'd0, bus_t.ir_write, bus_t.pc_write, bus_t.reg_write,
                           bus_t.mem_write}, 8'd0);
    cyc();
    check("halt_enables_2", {4'd0, bus_t.ir_write, bus_t.pc_write, bus_t.reg_write,
                             bus_t.mem_write}, 8'd0);

    // sw, reset asserted in MEMWRITE while waiting
    cyc();
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("sw_mem_write", {7'd0, bus.mem_write}, 8'd1);
    check("sw_adr_src", {7'd0, bus.adr_src}, 8'd1);
    check("sw_wait_done", {7'd0, bus.instr_done}, 8'd0);
    reset = 1'b1;
    #1;
    check("sw_rst_mem_write", {7'd0, bus.mem_write}, 8'd0);
    cyc();
    check("rst_fetch_src_b", {6'd0, bus.alu_src_b}, 8'd2);
    check("rst_fetch_adr_src", {7'd0, bus.adr_src}, 8'd0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("post_rst_ir_write", {7'd0, bus.ir_write}, 8'd1);
    check("trap_left_halt", {7'd0, bus_t.ir_write}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
